// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the P7 coprocessor-0 block.
// Holds CP0 register numbers, SR/Cause bit-field positions, the MIPS
// ExcCode values used by the pipeline, and the exception handler entry.
package cp0_pkg;

    // CP0 register numbers addressed by mfc0/mtc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // SR field positions
    localparam int SR_IE_BIT  = 0;
    localparam int SR_EXL_BIT = 1;
    localparam int SR_IM_LO   = 10;
    localparam int SR_IM_HI   = 15;

    // Cause field positions
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_EXC_HI = 6;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_IP_HI  = 15;
    localparam int CAUSE_BD_BIT = 31;

    // Exception codes carried in Cause.ExcCode
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;

    // Exception entry address; consumed by the PC selection logic
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_unit_if.sv
// cp0_unit_if: pipeline <-> CP0 signal bundle.
//   master : M-stage pipeline side (drives mfc0/mtc0, exception bundle, IRQs)
//   slave  : CP0 side (returns Req, DOut, EPCOut)
interface cp0_unit_if;
    logic [4:0]  A1;         // mfc0 read register number
    logic [4:0]  A2;         // mtc0 write register number
    logic [31:0] DIn;        // mtc0 write data
    logic        WE;         // mtc0 write enable
    logic [31:0] VPC;        // M-stage PC of victim
    logic        BDIn;       // victim sits in a branch delay slot
    logic [4:0]  ExcCodeIn;  // pending exception code, 0 = none
    logic [5:0]  HWInt;      // external interrupt lines
    logic        EXLClr;     // eret retiring in M stage
    logic        Req;        // trap / flush request (combinational)
    logic [31:0] DOut;       // mfc0 read data (combinational)
    logic [31:0] EPCOut;     // current EPC

    modport master (
        output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  Req, DOut, EPCOut
    );

    modport slave (
        input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output Req, DOut, EPCOut
    );
endinterface

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 exception/interrupt controller.
// Decides whether the M-stage instruction traps (Req), records the trap in
// SR/Cause/EPC, serves mfc0/mtc0 and clears EXL on eret.
// Ports:
//   clk   - system clock, state changes on rising edge
//   reset - asynchronous active-low reset
//   bus   - cp0_unit_if.slave (A1/A2/DIn/WE mfc0/mtc0, VPC/BDIn/ExcCodeIn
//           exception bundle, HWInt, EXLClr; outputs Req, DOut, EPCOut)
module cp0_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h2206_0007
) (
    input  logic       clk,
    input  logic       reset,
    cp0_unit_if.slave  bus
);

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic [31:0] vpc_aligned_s;
    logic [31:0] epc_next_s;
    logic [31:0] sr_word_s;
    logic [31:0] cause_word_s;
    logic [31:0] dout_s;

    // Trap decision and victim EPC; EXL masks both interrupts and exceptions
    always_comb begin
        int_req_s     = ie_r & ~exl_r & (|(bus.HWInt & im_r));
        exc_req_s     = ~exl_r & (bus.ExcCodeIn != 5'd0);
        req_s         = int_req_s | exc_req_s;
        vpc_aligned_s = {bus.VPC[31:2], 2'b00};
        // A delay-slot victim restarts at its branch, one word earlier
        if (bus.BDIn) begin
            epc_next_s = vpc_aligned_s - 32'd4;
        end else begin
            epc_next_s = vpc_aligned_s;
        end
    end

    // Assemble architectural SR/Cause views and the mfc0 read mux
    always_comb begin
        sr_word_s                          = 32'd0;
        sr_word_s[SR_IM_HI:SR_IM_LO]       = im_r;
        sr_word_s[SR_EXL_BIT]              = exl_r;
        sr_word_s[SR_IE_BIT]               = ie_r;
        cause_word_s                       = 32'd0;
        cause_word_s[CAUSE_BD_BIT]         = bd_r;
        cause_word_s[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_r;
        cause_word_s[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_r;
        case (bus.A1)
            REG_SR:    dout_s = sr_word_s;
            REG_CAUSE: dout_s = cause_word_s;
            REG_EPC:   dout_s = epc_r;
            REG_PRID:  dout_s = PRID_VALUE;
            default:   dout_s = 32'd0;
        endcase
    end

    assign bus.Req    = req_s;
    assign bus.DOut   = dout_s;
    assign bus.EPCOut = epc_r;

    // CP0 state: trap commit beats eret, eret beats mtc0; IP samples every edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            ip_r <= bus.HWInt;
            if (req_s) begin
                exl_r      <= 1'b1;
                exc_code_r <= int_req_s ? EXC_INT : bus.ExcCodeIn;
                bd_r       <= bus.BDIn;
                epc_r      <= epc_next_s;
            end else if (bus.EXLClr) begin
                exl_r <= 1'b0;
            end else if (bus.WE) begin
                case (bus.A2)
                    REG_SR: begin
                        im_r  <= bus.DIn[SR_IM_HI:SR_IM_LO];
                        exl_r <= bus.DIn[SR_EXL_BIT];
                        ie_r  <= bus.DIn[SR_IE_BIT];
                    end
                    REG_EPC: epc_r <= bus.DIn;
                    default: ; // Cause, PRId and unimplemented registers are read-only
                endcase
            end else begin
                exl_r <= exl_r;
            end
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
`timescale 1ns/1ps
// tb_cp0_unit: directed + randomized bench for cp0_unit against a word-level
// reference model of SR/Cause/EPC.
module tb_cp0_unit;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    cp0_unit_if bus ();

    cp0_unit #(.PRID_VALUE(32'h2206_0007)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register words
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic logic model_int_req();
        return m_sr[0] && !m_sr[1] && ((bus.HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic model_exc_req();
        return !m_sr[1] && (bus.ExcCodeIn != 5'd0);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h2206_0007;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_update();
        logic irq;
        logic exq;
        logic [31:0] base;
        irq = model_int_req();
        exq = model_exc_req();
        m_cause[15:10] = bus.HWInt;
        if (irq || exq) begin
            m_sr[1]       = 1'b1;
            m_cause[6:2]  = irq ? 5'd0 : bus.ExcCodeIn;
            m_cause[31]   = bus.BDIn;
            base          = bus.VPC & 32'hFFFF_FFFC;
            m_epc         = bus.BDIn ? base - 32'd4 : base;
        end else if (bus.EXLClr) begin
            m_sr[1] = 1'b0;
        end else if (bus.WE) begin
            if (bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
            else if (bus.A2 == 5'd14) m_epc = bus.DIn;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare outputs with the model, then let one edge happen
    task automatic cycle(input string tag);
        #1;
        check({tag, "_req"},  {31'd0, bus.Req}, {31'd0, (model_int_req() | model_exc_req())});
        check({tag, "_dout"}, bus.DOut, model_read(bus.A1));
        check({tag, "_epc"},  bus.EPCOut, m_epc);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.A1 = 5'd12; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0;
        bus.VPC = 32'd0; bus.BDIn = 1'b0; bus.ExcCodeIn = 5'd0;
        bus.HWInt = 6'd0; bus.EXLClr = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; errors = 0; checks = 0;
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        idle_inputs();
        @(negedge clk);
        #1;
        check("reset_req", {31'd0, bus.Req}, 32'd0);
        check("reset_sr", bus.DOut, 32'd0);
        check("reset_epc", bus.EPCOut, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // mtc0 SR <- IM0|IE, then interrupt line 0
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        cycle("mtc0_sr");
        bus.WE = 1'b0; bus.HWInt = 6'b000001; bus.VPC = 32'h0000_3000;
        #1 check("irq_req", {31'd0, bus.Req}, 32'd1);
        cycle("irq");
        bus.HWInt = 6'd0; bus.A1 = 5'd13;
        #1 check("irq_req_drop", {31'd0, bus.Req}, 32'd0);
        check("irq_cause", bus.DOut, 32'h0000_0400);
        check("irq_epc", bus.EPCOut, 32'h0000_3000);
        cycle("irq_after");
        bus.A1 = 5'd12;
        #1 check("irq_sr", bus.DOut, 32'h0000_0403);

        // eret, then overflow in a delay slot
        bus.EXLClr = 1'b1;
        cycle("eret1");
        bus.EXLClr = 1'b0; bus.ExcCodeIn = 5'd12; bus.BDIn = 1'b1; bus.VPC = 32'h0000_3010;
        #1 check("ov_req", {31'd0, bus.Req}, 32'd1);
        cycle("ov");
        bus.ExcCodeIn = 5'd0; bus.BDIn = 1'b0; bus.A1 = 5'd13;
        #1 check("ov_cause", bus.DOut, 32'h8000_0030);
        check("ov_epc", bus.EPCOut, 32'h0000_300C);
        cycle("ov_after");

        // interrupt beats AdEL; mtc0 EPC in trap cycle discarded
        bus.EXLClr = 1'b1;
        cycle("eret2");
        bus.EXLClr = 1'b0; bus.ExcCodeIn = 5'd4; bus.HWInt = 6'b000001;
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_5000; bus.VPC = 32'h0000_3020;
        cycle("int_vs_exc");
        bus.WE = 1'b0; bus.ExcCodeIn = 5'd0; bus.HWInt = 6'd0; bus.A1 = 5'd13;
        #1 check("prio_cause", bus.DOut, 32'h0000_0400);
        check("prio_epc", bus.EPCOut, 32'h0000_3020);
        cycle("prio_after");

        // EXL masks syscall; eret unmasks a pending interrupt
        bus.ExcCodeIn = 5'd8;
        #1 check("exl_mask_req", {31'd0, bus.Req}, 32'd0);
        cycle("exl_mask");
        bus.ExcCodeIn = 5'd0;
        #1 check("exl_mask_epc", bus.EPCOut, 32'h0000_3020);
        bus.EXLClr = 1'b1; bus.HWInt = 6'b000001;
        #1 check("eret_req", {31'd0, bus.Req}, 32'd0);
        cycle("eret3");
        bus.EXLClr = 1'b0; bus.VPC = 32'h0000_3030;
        #1 check("pending_req", {31'd0, bus.Req}, 32'd1);
        cycle("pending");
        bus.HWInt = 6'd0;

        // PRId and IP latency
        bus.A1 = 5'd15;
        #1 check("prid", bus.DOut, 32'h2206_0007);
        bus.A1 = 5'd13; bus.HWInt = 6'b100000;
        cycle("ip5_set");
        bus.HWInt = 6'd0;
        #1 check("ip5_bit", {31'd0, bus.DOut[15]}, 32'd1);
        cycle("ip5_after");

        // reset mid-run with EXL=1, EPC=3008
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3008;
        cycle("epc_3008");
        bus.WE = 1'b0;
        #1 check("epc_3008_val", bus.EPCOut, 32'h0000_3008);
        reset = 1'b0;
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
        bus.A1 = 5'd12;
        #1 check("rst_sr", bus.DOut, 32'd0);
        check("rst_req", {31'd0, bus.Req}, 32'd0);
        bus.A1 = 5'd13;
        #1 check("rst_cause", bus.DOut, 32'd0);
        bus.A1 = 5'd14;
        #1 check("rst_epc_rd", bus.DOut, 32'd0);
        check("rst_epc", bus.EPCOut, 32'd0);
        bus.ExcCodeIn = 5'd8;
        #1 check("rst_exc_req", {31'd0, bus.Req}, 32'd1);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.A1        = 5'($urandom_range(10, 16));
            bus.A2        = 5'($urandom_range(11, 16));
            bus.DIn       = $urandom;
            bus.WE        = 1'($urandom_range(0, 1));
            bus.VPC       = $urandom;
            bus.BDIn      = 1'($urandom_range(0, 1));
            bus.ExcCodeIn = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
            bus.HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr    = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_unit.md
# cp0_unit

Coprocessor-0 exception/interrupt controller for the P7 five-stage MIPS pipeline. It consumes the M-stage exception bundle (PC, branch-delay flag, pending exception code) and the six external hardware interrupt lines. It decides whether the pipeline must trap and raises `Req`, the flush request that every pipeline register, including the E→M register, acts on. It also holds SR/Cause/EPC/PRId, serves `mfc0`/`mtc0`, supplies EPC for `eret`, and clears EXL on `eret`.

## Interface
- `PRID_VALUE`, default 32'h2206_0007: read-only PRId contents.
- `HANDLER_PC`, default 32'h0000_4180: exception entry address; documented only, used by the PC logic.
- `clk  in  1  system clock; all state updates on rising edge`
- `reset  in  1  asynchronous, active-low reset (0 = reset)`
- `A1  in  5  mfc0 read register number`
- `A2  in  5  mtc0 write register number`
- `DIn  in  32  mtc0 write data (M-stage RD2)`
- `WE  in  1  mtc0 write enable (M stage)`
- `VPC  in  32  M-stage PC of the victim instruction`
- `BDIn  in  1  victim is in a branch delay slot`
- `ExcCodeIn  in  5  M-stage pending exception code; 0 = none`
- `HWInt  in  6  external interrupt lines [5:0] (timer0, timer1, interrupt generator, …)`
- `EXLClr  in  1  eret retiring in M stage`
- `Req  out  1  trap request; combinational`
- `DOut  out  32  mfc0 read data; combinational`
- `EPCOut  out  32  current EPC register`

## Operation
- Registers:
  - SR (12): IM = [15:10], EXL = [1], IE = [0]. All other bits read 0.
  - Cause (13): BD = [31], IP = [15:10], ExcCode = [6:2]. Other bits 0.
  - EPC (14): 32 bits.
  - PRId (15): constant `PRID_VALUE`.
  - Any other `A1` reads 0.
- Trap decision:
  - IntReq = IE & ~EXL & |(HWInt & IM).
  - ExcReq = ~EXL & (ExcCodeIn != 0).
  - `Req` = IntReq | ExcReq.
  - Interrupt has priority over exception.
- On a clock edge with `Req`=1:
  - EXL ← 1.
  - Cause.ExcCode ← IntReq ? 0 : ExcCodeIn.
  - Cause.BD ← BDIn.
  - EPC ← BDIn ? {VPC[31:2],2'b00} − 4 : {VPC[31:2],2'b00}.
- Cause.IP ← HWInt on every edge, independent of other events.
- mtc0: when `WE` & ~`Req`, write takes effect at the edge.
  - A2=12 writes IM/EXL/IE.
  - A2=14 writes EPC.
  - Writes to 13, 15 and others are ignored.
- eret: `EXLClr` & ~`Req` clears EXL at the edge.
- Priority at one edge: trap > eret > mtc0. An mtc0 to EPC in the trap cycle is discarded.
- `DOut` reflects register state before the edge (no write-through of the same-cycle mtc0).
- Reset (asynchronous, while `reset`=0): SR=0, Cause=0, EPC=0. Consequences: `Req`=0 unless ExcCodeIn≠0; `DOut` per A1; `EPCOut`=0.

## Timing
- `Req` is combinational from inputs and SR in the same cycle. The PC logic and pipeline registers sample it at the same edge CP0 commits the trap.
- EXL is set one edge after `Req`. `Req` can drop the next cycle (EXL masks further traps) with no pulse stretching.
- ExcCode/BD/EPC are visible on `DOut`/`EPCOut` the cycle after the trap edge.
- mtc0→mfc0 of the same register: new value visible from the next cycle.
- `HWInt` is level-sensitive. IP tracks it with 1-cycle latency. The trap decision uses live `HWInt`.
- Reset deassertion is synchronized externally. The first edge after release performs normal updates.

## Structure
- Shared package `cp0_pkg` holds:
  - register numbers (12–15);
  - SR/Cause bit-field positions;
  - ExcCode constants: Int=0, AdEL=4, AdES=5, Syscall=8, RI=10, Ov=12;
  - `HANDLER_PC`.
- Single flat module. No sub-module is warranted; the trap-decision logic is a few lines of combinational code.

## Test plan
- Reset low mid-run with EXL=1, EPC=32'h3008 → all registers read 0 immediately, `Req`=0.
- mtc0 SR←32'h0000_0401, then HWInt=6'b000001 → `Req`=1 that cycle. Next cycle: EXL=1, ExcCode=0, EPC=VPC, `Req`=0.
- ExcCodeIn=12 (Ov), BDIn=1, VPC=32'h3010 → EPC=32'h300C, Cause.BD=1, ExcCode=12.
- Same cycle: ExcCodeIn=4 and enabled HWInt → ExcCode=0 (interrupt wins). An mtc0 EPC←32'h5000 in that cycle is ignored.
- EXL=1 with ExcCodeIn=8 → `Req`=0, no state change. Then EXLClr → EXL=0, and a pending enabled interrupt raises `Req` the next cycle.
- mfc0 A1=15 → 32'h2206_0007. A1=13 after HWInt=6'b100000 → bit 15 set one cycle later.
